digit_scan_driver: RTL and testbench
====================================

Name: digit_scan_driver

Overview:
- Time-multiplexed scan controller for the 4-digit 7-segment display.
- Steps through digit indices 0..3 at a programmable rate and drives `scan_idx`, which feeds the downstream anode decoder (index 0 enables the leftmost digit, active-low anode pattern 0111).
- Presents the BCD nibble and decimal point for the selected digit to the segment encoder.
- Holds double-buffered display data so that updates take effect only at frame boundaries, which keeps the display free of tearing.

Parameters:
- DIV, 50000, clock cycles per digit slot; legal range DIV >= 2.
- BLANK, 500, cycles at the start of each slot during which the digit is blanked (anti-ghosting); legal range 0 <= BLANK < DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- load  input  1  one-cycle strobe that captures din/dp_in
- din  input  16  four BCD digits; [15:12] = digit 0 (leftmost) ... [3:0] = digit 3
- dp_in  input  4  decimal points; bit 3 = digit 0 ... bit 0 = digit 3
- scan_idx  output  2  current digit index, to the anode decoder
- digit_en  output  1  high when the selected digit may be lit; low during blanking
- bcd  output  4  BCD value of the selected digit
- dp  output  1  decimal point of the selected digit
- frame_tick  output  1  one-cycle pulse at each frame start

Behaviour:
- Slot counter `div_cnt`:
  - Width is $clog2(DIV).
  - Counts 0..DIV-1 and wraps to 0.
- Index advance: `scan_idx` increments when `div_cnt` = DIV-1 and wraps 3 -> 0.
- Slot and frame length: each index is held for exactly DIV cycles; one full frame is 4*DIV cycles.
- `digit_en`: equals 0 while `div_cnt` < BLANK, otherwise 1. When BLANK = 0, `digit_en` is constantly 1 after reset.
- `bcd` and `dp`: combinational selects from the active buffer using `scan_idx`.
- `bcd` during blanking: forced to 4'hF (segment encoder renders this as blank); `dp` is forced to 0.
- `frame_tick`: registered; high for exactly the one cycle in which `scan_idx` = 0 and `div_cnt` = 0 following a 3 -> 0 wrap. It does not pulse on the first cycle after reset.
- Buffers:
  - The `active` buffer is 20 bits (din plus dp_in) and drives the outputs.
  - The `pending` buffer is 20 bits, with a `pend_v` flag.
- Load outside a frame boundary: pending <= {din, dp_in} and pend_v <= 1. A later load overwrites pending (last write wins).
- Frame boundary (cycle where `scan_idx` = 3 and `div_cnt` = DIV-1), no load: if pend_v, then active <= pending and pend_v <= 0.
- Load coincident with the boundary: active <= {din, dp_in} directly. Any older pending data is discarded and pend_v <= 0.
- Reset values:
  - Outputs: scan_idx = 0, div_cnt = 0, frame_tick = 0, and dp = 0.
  - Buffers: active = 20'h0, pending = 20'h0, pend_v = 0.
  - bcd is 0 when BLANK = 0 and 4'hF when BLANK > 0.
  - digit_en is 0 when BLANK > 0 and 1 when BLANK = 0.
- Reset asserted mid-frame: all state returns to the reset values immediately; pending data is lost. Scanning restarts at index 0, slot cycle 0, on the first clock edge after release.
- `load` has no handshake and is always accepted.

Optional Feature:
- Macro: LZ_SUPPRESS_EN.
- When defined:
  - Leading-zero suppression is applied to digits 0..2. A digit whose value is 0 and whose more-significant digits are all 0 outputs bcd = 4'hF, while `digit_en` keeps its normal behaviour.
  - Digit 3 is never suppressed.
  - The `dp` bit of a suppressed digit is still shown.
  - Suppression is evaluated on the active buffer only.
- When not defined: all digits display their value as stored.

Test Plan:
All scenarios use DIV = 4 and BLANK = 1.
1. Reset release, then run 16 cycles -> scan_idx sequence is 0,0,0,0,1,1,1,1,2,...,3, and digit_en pattern within each slot is 0,1,1,1. frame_tick pulses at cycle 16 and not at cycle 0.
2. load with din = 16'h1234 and dp_in = 4'b0100 in mid-frame -> outputs keep showing 0000 until the next frame tick. After the tick, the lit cycles of the frame show bcd 1,2,3,4 with dp = 1 only on digit 1.
3. Two loads in one frame (16'h1111, then 16'h2222) -> the next frame shows 2222 and 1111 never appears.
4. load of 16'h9876 exactly on the boundary cycle (scan_idx = 3, div_cnt = 3), with 16'h5555 already pending -> the next frame shows 9876 and pend_v = 0 afterwards.
5. Assert rst at scan_idx = 2 with a load pending -> outputs return to reset values within the same cycle. After release, scanning restarts at index 0 and displays 0000.
6. With LZ_SUPPRESS_EN defined and din = 16'h0040 -> lit bcd sequence is F,F,4,0. With din = 16'h0000 -> lit bcd sequence is F,F,F,0.

Source files
------------

// File: rtl/digit_scan_driver.sv
// Scan controller for a 4-digit 7-segment display with frame-synchronous double-buffered data.
// Optional leading-zero suppression on digits 0..2 when LZ_SUPPRESS_EN is defined.
module digit_scan_driver #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  output logic [1:0]  scan_idx,
  output logic        digit_en,
  output logic [3:0]  bcd,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;
  logic [19:0]   active;
  logic [19:0]   pending;
  logic          pend_v;
  logic          slot_end;
  logic          frame_end;
  logic          blank;
  logic [3:0]    dig;
  logic          dp_sel;
  logic          lz;

  assign slot_end  = (div_cnt == LAST);
  assign frame_end = slot_end && (scan_idx == 2'd3);

  generate
    if (BLANK == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BL = CW'(BLANK);
      assign blank = (div_cnt < BL);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      scan_idx   <= 2'd0;
      frame_tick <= 1'b0;
      active     <= 20'h0;
      pending    <= 20'h0;
      pend_v     <= 1'b0;
    end else begin
      div_cnt    <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end)
        scan_idx <= scan_idx + 2'd1;
      frame_tick <= frame_end;
      // A load on the boundary bypasses pending so the newest data wins.
      if (frame_end) begin
        if (load)
          active <= {din, dp_in};
        else if (pend_v)
          active <= pending;
        pend_v <= 1'b0;
      end else if (load) begin
        pending <= {din, dp_in};
        pend_v  <= 1'b1;
      end
    end
  end

  always_comb begin
    dig    = 4'h0;
    dp_sel = 1'b0;
    lz     = 1'b0;
    case (scan_idx)
      2'd0: begin dig = active[19:16]; dp_sel = active[3]; end
      2'd1: begin dig = active[15:12]; dp_sel = active[2]; end
      2'd2: begin dig = active[11:8];  dp_sel = active[1]; end
      default: begin dig = active[7:4]; dp_sel = active[0]; end
    endcase
`ifdef LZ_SUPPRESS_EN
    case (scan_idx)
      2'd0: lz = (active[19:16] == 4'h0);
      2'd1: lz = (active[19:12] == 8'h00);
      2'd2: lz = (active[19:8] == 12'h000);
      default: lz = 1'b0;
    endcase
`endif
    digit_en = ~blank;
    bcd      = (blank || lz) ? 4'hF : dig;
    dp       = blank ? 1'b0 : dp_sel;
  end

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver with DIV=4, BLANK=1; expectations follow the
// LZ_SUPPRESS_EN setting of the build.
module tb_digit_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [1:0]  scan_idx;
  logic        digit_en;
  logic [3:0]  bcd;
  logic        dp;
  logic        frame_tick;

  int total = 0;
  int bad = 0;

  digit_scan_driver #(.DIV(4), .BLANK(1)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .dp_in(dp_in),
    .scan_idx(scan_idx), .digit_en(digit_en), .bcd(bcd), .dp(dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_bcd(input logic [15:0] val, input int k);
    logic [3:0] d;
    logic       sup;
    d   = val[15-4*k -: 4];
    sup = 1'b0;
`ifdef LZ_SUPPRESS_EN
    case (k)
      0: sup = (val[15:12] == 4'h0);
      1: sup = (val[15:8] == 8'h00);
      2: sup = (val[15:4] == 12'h000);
      default: sup = 1'b0;
    endcase
`endif
    return sup ? 4'hF : d;
  endfunction

  // Called at a negedge where the DUT sits at scan_idx=0, div_cnt=0. Checks ncyc cycles
  // against the expected display value, optionally pulsing load at cycles la and lb.
  task automatic run_frame(input string nm, input logic [15:0] val, input logic [3:0] dpv,
                           input bit tick0, input int ncyc,
                           input int la, input logic [15:0] da, input logic [3:0] pa,
                           input int lb, input logic [15:0] db, input logic [3:0] pb);
    for (int i = 0; i < ncyc; i++) begin
      int k;
      int s;
      k = i / 4;
      s = i % 4;
      chk($sformatf("%s idx c%0d", nm, i), 32'(scan_idx), 32'(k));
      chk($sformatf("%s en c%0d", nm, i), 32'(digit_en), 32'(s != 0));
      chk($sformatf("%s bcd c%0d", nm, i), 32'(bcd), (s == 0) ? 32'hF : 32'(exp_bcd(val, k)));
      chk($sformatf("%s dp c%0d", nm, i), 32'(dp), (s == 0) ? 32'd0 : 32'(dpv[3-k]));
      chk($sformatf("%s tick c%0d", nm, i), 32'(frame_tick), 32'(tick0 && (i == 0)));
      load = 1'b0;
      if (i == la) begin load = 1'b1; din = da; dp_in = pa; end
      if (i == lb) begin load = 1'b1; din = db; dp_in = pb; end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " idx"}, 32'(scan_idx), 32'd0);
    chk({nm, " en"}, 32'(digit_en), 32'd0);
    chk({nm, " bcd"}, 32'(bcd), 32'hF);
    chk({nm, " dp"}, 32'(dp), 32'd0);
    chk({nm, " tick"}, 32'(frame_tick), 32'd0);
    chk({nm, " pend_v"}, 32'(dut.pend_v), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;

    // Scan order and blanking after release; no tick on the first frame start.
    run_frame("scan", 16'h0000, 4'h0, 1'b0, 16, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    // Mid-frame load stays invisible until the next frame.
    run_frame("pend", 16'h0000, 4'h0, 1'b1, 16, 6, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
    run_frame("show1234", 16'h1234, 4'b0100, 1'b1, 16, 3, 16'h1111, 4'h0, 9, 16'h2222, 4'h0);
    // Last write wins: 2222 shown, 1111 never.
    run_frame("show2222", 16'h2222, 4'h0, 1'b1, 16, 5, 16'h5555, 4'h0, 15, 16'h9876, 4'b1001);
    chk("boundary pend_v", 32'(dut.pend_v), 32'd0);
    run_frame("show9876", 16'h9876, 4'b1001, 1'b1, 16, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("keep9876", 16'h9876, 4'b1001, 1'b1, 10, 3, 16'h4321, 4'b1111, -1, 16'h0, 4'h0);

    // Reset mid-frame at scan_idx 2 with data pending.
    chk("pre-rst idx", 32'(scan_idx), 32'd2);
    chk("pre-rst pend_v", 32'(dut.pend_v), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_vals("rst1");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_frame("after rst", 16'h0000, 4'h0, 1'b0, 16, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("lost pend", 16'h0000, 4'h0, 1'b1, 16, 15, 16'h0040, 4'b0010, -1, 16'h0, 4'h0);

    // Leading-zero patterns (suppressed only when the feature is built in).
    run_frame("v0040", 16'h0040, 4'b0010, 1'b1, 16, 15, 16'h0000, 4'b1000, -1, 16'h0, 4'h0);
    run_frame("v0000", 16'h0000, 4'b1000, 1'b1, 16, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
